// File: rtl/query_bitserial_buffer.sv
// Double-buffered query-point store: loads points into a shadow bank and replays
// the active bank as a bit-plane-interleaved stream, NUM_Q bits per beat.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | no pass in flight, stream outputs held at zero
// S_STREAM | emitting one beat per cycle from the active bank
module query_bitserial_buffer #(
   parameter int DIMS      = 3,
   parameter int BIT_WIDTH = 16,
   parameter int MEM_WIDTH = 64,
   parameter int NUM_Q     = 1,
   parameter int MSB_FIRST = 1,
   localparam int L        = DIMS * BIT_WIDTH,
   localparam int DW       = (DIMS > 1) ? $clog2(DIMS) : 1,
   localparam int PW       = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_valid,
   input  logic [MEM_WIDTH-1:0] load_data,
   output logic                 load_ready,
   input  logic                 swap,
   input  logic                 stream_start,
   input  logic                 abort,
   output logic [NUM_Q-1:0]     q_bit,
   output logic                 q_bit_valid,
   output logic [DW-1:0]        q_dim,
   output logic [PW-1:0]        q_plane,
   output logic                 q_first,
   output logic                 q_last,
   output logic                 active_valid,
   output logic                 shadow_full,
   output logic                 swap_pending
);

   localparam int IW = (L > 1) ? $clog2(L) : 1;
   localparam int SW = $clog2(NUM_Q + 1);
   localparam logic [DW-1:0] DIM_LAST    = DW'(DIMS - 1);
   localparam logic [PW-1:0] PLANE_FIRST = (MSB_FIRST != 0) ? PW'(BIT_WIDTH - 1) : '0;
   localparam logic [PW-1:0] PLANE_LAST  = (MSB_FIRST != 0) ? '0 : PW'(BIT_WIDTH - 1);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t            state, state_n;
   logic [L-1:0]      bank [2][NUM_Q];
   logic              bsel, bsel_n;
   logic [SW-1:0]     slot_ctr;
   logic              load_acc, at_boundary, swap_exec, start_ok;
   logic              valid_n, first_n, last_n;
   logic [DW-1:0]     dim_n;
   logic [PW-1:0]     plane_n;
   logic [IW-1:0]     bit_idx;
   logic [NUM_Q-1:0]  bit_n;

   generate
      if (MEM_WIDTH > L) begin : g_hi
         logic unused_hi;
         assign unused_hi = ^load_data[MEM_WIDTH-1:L];
      end
   endgenerate

   assign load_ready  = !shadow_full;
   assign load_acc    = load_valid && !shadow_full;
   // A pass boundary is an idle cycle or a clean q_last; the raw swap input
   // counts alongside the latched request so swap+start lands on the new bank.
   assign at_boundary = !q_bit_valid || (q_last && !abort);
   assign swap_exec   = (swap || swap_pending) && shadow_full && at_boundary;
   assign start_ok    = stream_start && !abort && at_boundary && (active_valid || swap_exec);
   assign bsel_n      = swap_exec ? !bsel : bsel;

   always_comb begin
      state_n = state;
      valid_n = 1'b0;
      first_n = 1'b0;
      last_n  = 1'b0;
      dim_n   = '0;
      plane_n = '0;
      if (abort) begin
         state_n = S_IDLE;
      end else if (start_ok) begin
         state_n = S_STREAM;
         valid_n = 1'b1;
         first_n = 1'b1;
         plane_n = PLANE_FIRST;
         last_n  = (L == 1);
      end else if (state == S_STREAM && !q_last) begin
         valid_n = 1'b1;
         if (q_dim == DIM_LAST) begin
            dim_n   = '0;
            plane_n = (MSB_FIRST != 0) ? q_plane - PW'(1) : q_plane + PW'(1);
         end else begin
            dim_n   = q_dim + DW'(1);
            plane_n = q_plane;
         end
         last_n = (dim_n == DIM_LAST) && (plane_n == PLANE_LAST);
      end else begin
         state_n = S_IDLE;
      end

      bit_idx = IW'(dim_n) * IW'(BIT_WIDTH) + IW'(plane_n);
      for (int i = 0; i < NUM_Q; i++) begin
         bit_n[i] = valid_n ? bank[bsel_n][i][bit_idx] : 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         bsel         <= 1'b0;
         slot_ctr     <= '0;
         active_valid <= 1'b0;
         shadow_full  <= 1'b0;
         swap_pending <= 1'b0;
         q_bit        <= '0;
         q_bit_valid  <= 1'b0;
         q_dim        <= '0;
         q_plane      <= '0;
         q_first      <= 1'b0;
         q_last       <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_Q; i++) begin
               bank[b][i] <= '0;
            end
         end
      end else begin
         state       <= state_n;
         bsel        <= bsel_n;
         q_bit       <= bit_n;
         q_bit_valid <= valid_n;
         q_dim       <= dim_n;
         q_plane     <= plane_n;
         q_first     <= first_n;
         q_last      <= last_n;
         if (swap_exec) begin
            active_valid <= 1'b1;
            swap_pending <= 1'b0;
            shadow_full  <= 1'b0;
            slot_ctr     <= '0;
         end else begin
            if (swap) swap_pending <= 1'b1;
            if (load_acc) begin
               for (int i = 0; i < NUM_Q; i++) begin
                  if (slot_ctr == SW'(i)) bank[!bsel][i] <= load_data[L-1:0];
               end
               slot_ctr <= slot_ctr + SW'(1);
               if (slot_ctr == SW'(NUM_Q - 1)) shadow_full <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_query_bitserial_buffer.sv
// Directed bench for query_bitserial_buffer: DIMS=3, BIT_WIDTH=4, NUM_Q=2, with
// an MSB-first and an LSB-first instance sharing the same stimulus.
module tb_query_bitserial_buffer;

   logic        clk = 1'b0;
   logic        rst, load_valid, swap, stream_start, abort;
   logic [15:0] load_data;

   logic       load_ready, q_bit_valid, q_first, q_last, active_valid, shadow_full, swap_pending;
   logic [1:0] q_bit, q_dim, q_plane;
   logic       l_load_ready, l_valid, l_first, l_last, l_active_valid, l_shadow_full, l_swap_pending;
   logic [1:0] l_bit, l_dim, l_plane;

   int check_cnt = 0;
   int pass_cnt  = 0;

   // beat-ordered bit of point 0x0A5C (dims C,5,A)
   bit exp_msb [12] = '{1,0,1, 1,1,0, 0,0,1, 0,1,0};
   bit exp_lsb [12] = '{0,1,0, 0,0,1, 1,1,0, 1,0,1};

   query_bitserial_buffer #(.DIMS(3), .BIT_WIDTH(4), .MEM_WIDTH(16), .NUM_Q(2), .MSB_FIRST(1)) u_dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .swap(swap), .stream_start(stream_start), .abort(abort), .q_bit(q_bit), .q_bit_valid(q_bit_valid),
      .q_dim(q_dim), .q_plane(q_plane), .q_first(q_first), .q_last(q_last), .active_valid(active_valid),
      .shadow_full(shadow_full), .swap_pending(swap_pending));

   query_bitserial_buffer #(.DIMS(3), .BIT_WIDTH(4), .MEM_WIDTH(16), .NUM_Q(2), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_ready(l_load_ready),
      .swap(swap), .stream_start(stream_start), .abort(abort), .q_bit(l_bit), .q_bit_valid(l_valid),
      .q_dim(l_dim), .q_plane(l_plane), .q_first(l_first), .q_last(l_last), .active_valid(l_active_valid),
      .shadow_full(l_shadow_full), .swap_pending(l_swap_pending));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [15:0] w);
      load_valid = 1'b1;
      load_data  = w;
      tick();
      load_valid = 1'b0;
      load_data  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      check_cnt++;
      if (q_bit_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", q_bit_valid); else pass_cnt++;
      check_cnt++;
      if (load_ready !== 1'b1) $display("FAIL reset_load_ready got=%b exp=1", load_ready); else pass_cnt++;
      check_cnt++;
      if ({active_valid, shadow_full, swap_pending} !== 3'b000)
         $display("FAIL reset_flags got=%b exp=000", {active_valid, shadow_full, swap_pending});
      else pass_cnt++;
      check_cnt++;
      if ({q_bit, q_dim, q_plane, q_first, q_last} !== 8'h00)
         $display("FAIL reset_stream got=%h exp=00", {q_bit, q_dim, q_plane, q_first, q_last});
      else pass_cnt++;
   endtask

   task automatic test_basic_pass();
      load_word(16'h0A5C);
      load_word(16'h0FFF);
      check_cnt++;
      if ({shadow_full, load_ready} !== 2'b10)
         $display("FAIL load_full got=%b exp=10", {shadow_full, load_ready});
      else pass_cnt++;
      swap = 1'b1;
      tick();
      swap = 1'b0;
      check_cnt++;
      if ({active_valid, shadow_full, swap_pending, load_ready} !== 4'b1001)
         $display("FAIL swap_exec got=%b exp=1001", {active_valid, shadow_full, swap_pending, load_ready});
      else pass_cnt++;
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      for (int b = 0; b < 12; b++) begin
         check_cnt++;
         if ({q_bit_valid, q_bit[0], q_bit[1]} !== {1'b1, exp_msb[b], 1'b1})
            $display("FAIL basic_bits beat=%0d got=%b exp=%b", b + 1,
                     {q_bit_valid, q_bit[0], q_bit[1]}, {1'b1, exp_msb[b], 1'b1});
         else pass_cnt++;
         check_cnt++;
         if ({q_dim, q_plane} !== {2'(b % 3), 2'(3 - b / 3)})
            $display("FAIL basic_dim_plane beat=%0d got=%0d/%0d exp=%0d/%0d", b + 1, q_dim, q_plane, b % 3, 3 - b / 3);
         else pass_cnt++;
         check_cnt++;
         if ({q_first, q_last} !== {b == 0, b == 11})
            $display("FAIL basic_first_last beat=%0d got=%b exp=%b", b + 1, {q_first, q_last}, {b == 0, b == 11});
         else pass_cnt++;
         tick();
      end
      check_cnt++;
      if ({q_bit_valid, q_bit, q_first, q_last} !== 5'b0)
         $display("FAIL basic_end got=%b exp=00000", {q_bit_valid, q_bit, q_first, q_last});
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      stream_start = 1'b1;
      tick();
      for (int b = 0; b < 24; b++) begin
         check_cnt++;
         if ({q_bit_valid, q_first, q_last} !== {1'b1, b == 0 || b == 12, b == 11 || b == 23})
            $display("FAIL b2b beat=%0d got=%b exp=%b", b + 1, {q_bit_valid, q_first, q_last},
                     {1'b1, b == 0 || b == 12, b == 11 || b == 23});
         else pass_cnt++;
         if (b == 23) stream_start = 1'b0;
         tick();
      end
      check_cnt++;
      if (q_bit_valid !== 1'b0) $display("FAIL b2b_stop got=%b exp=0", q_bit_valid); else pass_cnt++;
   endtask

   task automatic test_ping_pong();
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      for (int b = 0; b < 12; b++) begin
         check_cnt++;
         if ({q_bit_valid, q_bit[0]} !== {1'b1, exp_msb[b]})
            $display("FAIL pp_old beat=%0d got=%b exp=%b", b + 1, {q_bit_valid, q_bit[0]}, {1'b1, exp_msb[b]});
         else pass_cnt++;
         if (b == 11) begin
            check_cnt++;
            if ({q_last, swap_pending, shadow_full, active_valid} !== 4'b1111)
               $display("FAIL pp_pending got=%b exp=1111", {q_last, swap_pending, shadow_full, active_valid});
            else pass_cnt++;
         end
         load_valid   = (b < 2);
         load_data    = (b == 1) ? 16'h0111 : 16'h0000;
         swap         = (b == 4);
         stream_start = (b == 11);
         tick();
      end
      load_valid   = 1'b0;
      swap         = 1'b0;
      stream_start = 1'b0;
      check_cnt++;
      if ({load_ready, shadow_full, swap_pending, active_valid, q_first} !== 5'b10011)
         $display("FAIL pp_swapped got=%b exp=10011", {load_ready, shadow_full, swap_pending, active_valid, q_first});
      else pass_cnt++;
      // point 1 = 0x111: every dim equals 1, so only plane 0 (last three beats) is set
      for (int b = 0; b < 12; b++) begin
         check_cnt++;
         if ({q_bit_valid, q_bit} !== {1'b1, (b >= 9), 1'b0})
            $display("FAIL pp_new beat=%0d got=%b exp=%b", b + 1, {q_bit_valid, q_bit}, {1'b1, (b >= 9), 1'b0});
         else pass_cnt++;
         tick();
      end
      check_cnt++;
      if (q_bit_valid !== 1'b0) $display("FAIL pp_end got=%b exp=0", q_bit_valid); else pass_cnt++;
   endtask

   task automatic test_not_ready();
      do_reset();
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      check_cnt++;
      if (q_bit_valid !== 1'b0) $display("FAIL nr_start got=%b exp=0", q_bit_valid); else pass_cnt++;
      tick();
      check_cnt++;
      if (q_bit_valid !== 1'b0) $display("FAIL nr_start2 got=%b exp=0", q_bit_valid); else pass_cnt++;
      load_word(16'h0A5C);
      swap = 1'b1;
      tick();
      swap = 1'b0;
      check_cnt++;
      if ({swap_pending, active_valid, shadow_full} !== 3'b100)
         $display("FAIL nr_pending got=%b exp=100", {swap_pending, active_valid, shadow_full});
      else pass_cnt++;
      load_word(16'h0FFF);
      check_cnt++;
      if ({swap_pending, active_valid, shadow_full} !== 3'b101)
         $display("FAIL nr_full got=%b exp=101", {swap_pending, active_valid, shadow_full});
      else pass_cnt++;
      tick();
      check_cnt++;
      if ({swap_pending, active_valid, shadow_full, load_ready} !== 4'b0101)
         $display("FAIL nr_exec got=%b exp=0101", {swap_pending, active_valid, shadow_full, load_ready});
      else pass_cnt++;
   endtask

   task automatic test_abort_reset();
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      tick();
      tick();
      tick();
      check_cnt++;
      if ({q_bit_valid, q_dim, q_plane} !== {1'b1, 2'd0, 2'd2})
         $display("FAIL ab_beat4 got=%b exp=10010", {q_bit_valid, q_dim, q_plane});
      else pass_cnt++;
      abort        = 1'b1;
      stream_start = 1'b1;
      tick();
      abort        = 1'b0;
      stream_start = 1'b0;
      check_cnt++;
      if ({q_bit_valid, q_bit, q_dim, q_plane, q_first, q_last} !== 9'b0)
         $display("FAIL ab_zero got=%b exp=0", {q_bit_valid, q_bit, q_dim, q_plane, q_first, q_last});
      else pass_cnt++;
      tick();
      check_cnt++;
      if (q_bit_valid !== 1'b0) $display("FAIL ab_norestart got=%b exp=0", q_bit_valid); else pass_cnt++;
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      tick();
      check_cnt++;
      if (q_bit_valid !== 1'b1) $display("FAIL ab_restart got=%b exp=1", q_bit_valid); else pass_cnt++;
      load_valid = 1'b1;
      load_data  = 16'h0123;
      rst        = 1'b1;
      tick();
      rst        = 1'b0;
      load_valid = 1'b0;
      check_cnt++;
      if ({q_bit_valid, q_bit, q_dim, q_plane, q_first, q_last} !== 9'b0)
         $display("FAIL rst_stream got=%b exp=0", {q_bit_valid, q_bit, q_dim, q_plane, q_first, q_last});
      else pass_cnt++;
      check_cnt++;
      if ({load_ready, active_valid, shadow_full, swap_pending} !== 4'b1000)
         $display("FAIL rst_flags got=%b exp=1000", {load_ready, active_valid, shadow_full, swap_pending});
      else pass_cnt++;
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
      check_cnt++;
      if (q_bit_valid !== 1'b0) $display("FAIL rst_nostart got=%b exp=0", q_bit_valid); else pass_cnt++;
   endtask

   task automatic test_lsb_order();
      do_reset();
      load_word(16'h0A5C);
      load_word(16'h0FFF);
      swap         = 1'b1;
      stream_start = 1'b1;
      tick();
      swap         = 1'b0;
      stream_start = 1'b0;
      for (int b = 0; b < 12; b++) begin
         check_cnt++;
         if ({l_valid, l_bit[0], l_bit[1]} !== {1'b1, exp_lsb[b], 1'b1})
            $display("FAIL lsb_bits beat=%0d got=%b exp=%b", b + 1, {l_valid, l_bit[0], l_bit[1]},
                     {1'b1, exp_lsb[b], 1'b1});
         else pass_cnt++;
         check_cnt++;
         if ({l_dim, l_plane, l_first, l_last} !== {2'(b % 3), 2'(b / 3), b == 0, b == 11})
            $display("FAIL lsb_order beat=%0d got=%0d/%0d/%b%b exp=%0d/%0d/%b%b", b + 1, l_dim, l_plane,
                     l_first, l_last, b % 3, b / 3, b == 0, b == 11);
         else pass_cnt++;
         tick();
      end
      check_cnt++;
      if (l_valid !== 1'b0) $display("FAIL lsb_end got=%b exp=0", l_valid); else pass_cnt++;
   endtask

   initial begin
      rst          = 1'b1;
      load_valid   = 1'b0;
      load_data    = '0;
      swap         = 1'b0;
      stream_start = 1'b0;
      abort        = 1'b0;
      test_reset();
      test_basic_pass();
      test_back_to_back();
      test_ping_pong();
      test_not_ready();
      test_abort_reset();
      test_lsb_order();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
